// File: rtl/video_fetch_pkg.sv
// video_fetch_pkg
//   Shared definitions for the ZX screen video fetch path.
//   - fetch_state_t : states of the per-cell bitmap/attribute fetch sequencer
//   - SCREEN_LINES  : number of visible screen lines
//   - ATTR_BASE     : offset of the attribute area within the video page
package video_fetch_pkg;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_REQ_BMP,
    FS_WAIT_BMP,
    FS_REQ_ATR,
    FS_WAIT_ATR
  } fetch_state_t;

  localparam int          SCREEN_LINES = 192;
  localparam logic [14:0] ATTR_BASE    = 15'h1800;

endpackage

// File: rtl/video_fetch_zx_screen_addr.sv
// video_fetch_zx_screen_addr
//   Pure combinational ZX Spectrum screen address map. Given a screen line
//   and a character column, returns the offsets of the bitmap byte and the
//   attribute byte within the video page.
//   Ports:
//     line     in  8   screen line 0..191
//     col      in  5   character column 0..31
//     bmp_addr out 15  bitmap byte offset
//     atr_addr out 15  attribute byte offset
module video_fetch_zx_screen_addr #(
  parameter logic [14:0] ATTR_BASE = video_fetch_pkg::ATTR_BASE
) (
  input  logic [7:0]  line,
  input  logic [4:0]  col,
  output logic [14:0] bmp_addr,
  output logic [14:0] atr_addr
);

  // The bitmap is split into three thirds (line[7:6]); inside a third the
  // pixel row within the character (line[2:0]) is more significant than the
  // character row (line[5:3]), which gives the familiar interleaved layout.
  assign bmp_addr = {2'b00, line[7:6], line[2:0], line[5:3], col};

  // Attributes are linear: one byte per 8x8 cell, 32 cells per character row.
  assign atr_addr = ATTR_BASE + {5'b00000, line[7:3], col};

endmodule

// File: rtl/video_fetch.sv
// video_fetch
//   Requests the bitmap and attribute byte of every character cell on active
//   screen lines from the memory arbiter, double-buffers the pair and hands it
//   to the pixel serializer on cell_load. A cell slot that arrives while a
//   fetch is still running is dropped and reported on underrun.
//   Ports:
//     clk28              in   1   system clock
//     rst                in   1   synchronous reset, active-high
//     line_start         in   1   start-of-line pulse, clears the column count
//     line_active        in   1   current line is a visible screen line
//     line               in   8   screen line number
//     cell_tick          in   1   one pulse per cell slot
//     video_read_req     out  1   read request to the arbiter
//     video_read_addr    out  15  offset within the video page
//     video_read_req_ack in   1   arbiter accepted the request
//     video_data_valid   in   1   vd holds the requested byte
//     vd                 in   8   memory data bus
//     cell_load          in   1   serializer takes the buffered cell
//     pix_byte           out  8   bitmap byte of the loaded cell
//     attr_byte          out  8   attribute byte of the loaded cell
//     cell_valid         out  1   loaded bytes are real fetched data
//     underrun           out  1   a fetch missed its slot
module video_fetch #(
  parameter int          COLS      = 32,
  parameter logic [14:0] ATTR_BASE = video_fetch_pkg::ATTR_BASE
) (
  input  logic        clk28,
  input  logic        rst,
  input  logic        line_start,
  input  logic        line_active,
  input  logic [7:0]  line,
  input  logic        cell_tick,
  output logic        video_read_req,
  output logic [14:0] video_read_addr,
  input  logic        video_read_req_ack,
  input  logic        video_data_valid,
  input  logic [7:0]  vd,
  input  logic        cell_load,
  output logic [7:0]  pix_byte,
  output logic [7:0]  attr_byte,
  output logic        cell_valid,
  output logic        underrun
);

  import video_fetch_pkg::*;

  localparam logic [5:0] COLS_LIM = 6'(COLS);

  fetch_state_t state_q;
  fetch_state_t state_d;

  logic [5:0]  col;
  logic [14:0] bmp_now;
  logic [14:0] atr_now;
  logic [14:0] atr_addr_q;
  logic [7:0]  stage_pix;
  logic [7:0]  fbuf_pix;
  logic [7:0]  fbuf_attr;
  logic        buf_full;

  logic slot_open;
  logic fetch_start;
  logic slot_miss;
  logic cap_pix;
  logic cap_attr;

  video_fetch_zx_screen_addr #(
    .ATTR_BASE(ATTR_BASE)
  ) u_addr (
    .line    (line),
    .col     (col[4:0]),
    .bmp_addr(bmp_now),
    .atr_addr(atr_now)
  );

  // A cell slot counts only on active lines and only until the line's cells
  // are used up; it starts a fetch if the sequencer is free, otherwise the
  // slot is lost. Data strobes matter only in the two WAIT states, which is
  // what makes a data_valid left high by the arbiter harmless elsewhere.
  assign slot_open   = cell_tick && line_active && (col < COLS_LIM);
  assign fetch_start = slot_open && (state_q == FS_IDLE);
  assign slot_miss   = slot_open && (state_q != FS_IDLE);
  assign cap_pix     = (state_q == FS_WAIT_BMP) && video_data_valid;
  assign cap_attr    = (state_q == FS_WAIT_ATR) && video_data_valid;

  // Column counter: cleared at line start (which wins over a coinciding
  // tick), advanced by every open slot whether or not it fetched, and held
  // at COLS so extra ticks at the end of a line do nothing.
  always_ff @(posedge clk28) begin
    if (rst) begin
      col <= '0;
    end else if (line_start) begin
      col <= '0;
    end else if (slot_open) begin
      col <= col + 6'd1;
    end
  end

  // Fetch sequencer state register.
  always_ff @(posedge clk28) begin
    if (rst) begin
      state_q <= FS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fetch sequencer next state: bitmap read then attribute read, each one a
  // request phase that waits for the ack and a data phase that waits for the
  // returned byte. There is deliberately no timeout on the ack.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FS_IDLE:     if (fetch_start)        state_d = FS_REQ_BMP;
      FS_REQ_BMP:  if (video_read_req_ack) state_d = FS_WAIT_BMP;
      FS_WAIT_BMP: if (video_data_valid)   state_d = FS_REQ_ATR;
      FS_REQ_ATR:  if (video_read_req_ack) state_d = FS_WAIT_ATR;
      FS_WAIT_ATR: if (video_data_valid)   state_d = FS_IDLE;
      default:                             state_d = FS_IDLE;
    endcase
  end

  // Request port. req is registered from the next state so it is high for
  // exactly the cycles spent in a request state and drops right after the
  // ack. The address is loaded once when a request phase is entered and is
  // otherwise left alone, so it is stable throughout the request and keeps
  // the last requested offset afterwards. The attribute offset is captured
  // at fetch start together with the bitmap offset, so a change of line or
  // column during the fetch cannot split a cell across two positions.
  always_ff @(posedge clk28) begin
    if (rst) begin
      video_read_req  <= 1'b0;
      video_read_addr <= '0;
      atr_addr_q      <= '0;
    end else begin
      video_read_req <= (state_d == FS_REQ_BMP) || (state_d == FS_REQ_ATR);
      if (fetch_start) begin
        video_read_addr <= bmp_now;
        atr_addr_q      <= atr_now;
      end else if (cap_pix) begin
        video_read_addr <= atr_addr_q;
      end
    end
  end

  // Data path. The bitmap byte waits in a staging register until its
  // attribute arrives, so the fetch buffer only ever changes as a complete
  // pair and a load in the middle of a fetch still sees a consistent cell.
  // The load is evaluated against the buffer as it was before this edge; a
  // pair completing on the same edge is written after it and stays
  // buffered for the next load.
  always_ff @(posedge clk28) begin
    if (rst) begin
      stage_pix  <= '0;
      fbuf_pix   <= '0;
      fbuf_attr  <= '0;
      buf_full   <= 1'b0;
      pix_byte   <= '0;
      attr_byte  <= '0;
      cell_valid <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= slot_miss;
      if (cap_pix) begin
        stage_pix <= vd;
      end
      if (cell_load) begin
        if (buf_full) begin
          pix_byte   <= fbuf_pix;
          attr_byte  <= fbuf_attr;
          cell_valid <= 1'b1;
          buf_full   <= 1'b0;
        end else begin
          cell_valid <= 1'b0;
        end
      end
      if (cap_attr) begin
        fbuf_pix  <= stage_pix;
        fbuf_attr <= vd;
        buf_full  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_fetch.sv
// tb_video_fetch
//   Drives video_fetch through several screen lines with a randomised
//   arbiter (ack and data delays, stale data_valid, late strobes after a
//   reset) and compares every cycle against a transaction-level model: a
//   queue of reads the screen map says must be issued, a memory image that
//   supplies the data, and a one-entry cell buffer.
module tb_video_fetch;
  import video_fetch_pkg::*;

  localparam int COLS = 32;

  logic        clk28 = 1'b0;
  logic        rst;
  logic        line_start;
  logic        line_active;
  logic [7:0]  line;
  logic        cell_tick;
  logic        video_read_req;
  logic [14:0] video_read_addr;
  logic        video_read_req_ack;
  logic        video_data_valid;
  logic [7:0]  vd;
  logic        cell_load;
  logic [7:0]  pix_byte;
  logic [7:0]  attr_byte;
  logic        cell_valid;
  logic        underrun;

  video_fetch #(.COLS(COLS), .ATTR_BASE(15'h1800)) dut (
    .clk28             (clk28),
    .rst               (rst),
    .line_start        (line_start),
    .line_active       (line_active),
    .line              (line),
    .cell_tick         (cell_tick),
    .video_read_req    (video_read_req),
    .video_read_addr   (video_read_addr),
    .video_read_req_ack(video_read_req_ack),
    .video_data_valid  (video_data_valid),
    .vd                (vd),
    .cell_load         (cell_load),
    .pix_byte          (pix_byte),
    .attr_byte         (attr_byte),
    .cell_valid        (cell_valid),
    .underrun          (underrun)
  );

  always #18 clk28 = ~clk28;

  typedef struct {
    logic [14:0] addr;
    bit          is_attr;
  } rd_t;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [0:32767];
  rd_t         rq[$];
  int          m_col;
  bit          m_busy;
  bit          m_full;
  logic [7:0]  m_buf_pix, m_buf_attr, m_pend_pix;
  logic [7:0]  m_pix, m_attr;
  bit          m_cell_valid, m_underrun;
  logic [14:0] m_last_addr;
  bit          acked;
  int          wait_cnt, data_cnt;
  int          mode;
  bit          stray_en;
  int          late_pulse;
  bit          rst_pending;
  int          fetches;

  // Screen map written as plain arithmetic: third, pixel row, char row, col.
  function automatic logic [14:0] exp_bmp(input int ln, input int c);
    return 15'((ln / 64) * 2048 + (ln % 8) * 256 + ((ln / 8) % 8) * 32 + c);
  endfunction

  function automatic logic [14:0] exp_atr(input int ln, input int c);
    return 15'(6144 + (ln / 8) * 32 + c);
  endfunction

  function automatic int pick_wait();
    if (mode == 0) return 0;
    if (mode == 2) return 12;
    if ($urandom_range(0, 7) == 0) return $urandom_range(30, 40);
    return $urandom_range(0, 4);
  endfunction

  function automatic int pick_data();
    if (mode == 1) return $urandom_range(0, 3);
    return 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    m_col        = 0;
    m_busy       = 0;
    m_full       = 0;
    m_pix        = '0;
    m_attr       = '0;
    m_cell_valid = 0;
    m_underrun   = 0;
    m_last_addr  = '0;
    acked        = 0;
    wait_cnt     = pick_wait();
    data_cnt     = 0;
  endtask

  // One clock: choose the arbiter's answer from the outstanding reads, drive
  // all inputs, advance the model on the edge, then compare all outputs.
  task automatic applyStimulus(input bit r, input bit ls, input bit act,
                               input bit tk, input bit ld, input logic [7:0] ln);
    bit         ack_i, val_i, slot, busy_old, done_now;
    logic [7:0] vd_i;
    rd_t        rd;
    ack_i = 0;
    val_i = 0;
    vd_i  = 8'($urandom);
    if (rq.size() > 0 && !acked) begin
      ack_i = (wait_cnt == 0);
      if (wait_cnt > 0) wait_cnt--;
      val_i = stray_en && ($urandom_range(0, 1) == 1);
    end else if (rq.size() > 0 && acked) begin
      if (data_cnt == 0) begin
        val_i = 1;
        vd_i  = mem[rq[0].addr];
      end else begin
        data_cnt--;
      end
    end else if (late_pulse > 0) begin
      ack_i = 1;
      val_i = 1;
      late_pulse--;
    end else begin
      val_i = stray_en && ($urandom_range(0, 1) == 1);
    end

    rst                = r;
    line_start         = ls;
    line_active        = act;
    line               = ln;
    cell_tick          = tk;
    cell_load          = ld;
    video_read_req_ack = ack_i;
    video_data_valid   = val_i;
    vd                 = vd_i;

    @(posedge clk28);
    if (r) begin
      model_reset();
    end else begin
      done_now = 0;
      slot     = tk && act && (m_col < COLS);
      busy_old = m_busy;
      if (ld) begin
        if (m_full) begin
          m_pix        = m_buf_pix;
          m_attr       = m_buf_attr;
          m_cell_valid = 1;
          m_full       = 0;
        end else begin
          m_cell_valid = 0;
        end
      end
      if (rq.size() > 0 && !acked && ack_i) begin
        acked    = 1;
        data_cnt = pick_data();
      end else if (rq.size() > 0 && acked && val_i) begin
        rd       = rq.pop_front();
        acked    = 0;
        wait_cnt = pick_wait();
        if (!rd.is_attr) begin
          m_pend_pix = mem[rd.addr];
        end else begin
          m_buf_pix  = m_pend_pix;
          m_buf_attr = mem[rd.addr];
          m_full     = 1;
          done_now   = 1;
        end
      end
      if (slot && !busy_old) begin
        rq.push_back('{addr: exp_bmp(ln, m_col), is_attr: 1'b0});
        rq.push_back('{addr: exp_atr(ln, m_col), is_attr: 1'b1});
        m_busy = 1;
        fetches++;
      end
      if (done_now) m_busy = 0;
      m_underrun = slot && busy_old;
      if (ls) m_col = 0;
      else if (slot) m_col++;
    end
    if (rq.size() > 0 && !acked) m_last_addr = rq[0].addr;

    #1;
    checkOutput("req", video_read_req, (rq.size() > 0 && !acked));
    checkOutput("addr", video_read_addr, m_last_addr);
    checkOutput("underrun", underrun, m_underrun);
    checkOutput("cell_valid", cell_valid, m_cell_valid);
    checkOutput("pix_byte", pix_byte, m_pix);
    checkOutput("attr_byte", attr_byte, m_attr);
  endtask

  // Runs one screen line: a line_start pulse, then 33 cell slots of 32
  // cycles (one more than the line holds) with a load at a random phase.
  task automatic run_line(input logic [7:0] ln, input bit act);
    bit r, ld;
    int ld_phase;
    applyStimulus(0, 1, act, 0, 0, ln);
    for (int c = 0; c < COLS + 1; c++) begin
      ld_phase = $urandom_range(1, 31);
      for (int k = 0; k < 32; k++) begin
        r = rst_pending && acked && (rq.size() > 0) && !rq[0].is_attr;
        if (r) begin
          rst_pending = 0;
          late_pulse  = 2;
        end
        ld = (k == ld_phase) || ($urandom_range(0, 15) == 0);
        applyStimulus(r, 0, act, (k == 0), ld, ln);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 32768; a++) mem[a] = 8'($urandom);
    mem[15'h0000] = 8'hAA;
    mem[15'h1800] = 8'h47;
    mode        = 0;
    stray_en    = 0;
    late_pulse  = 0;
    rst_pending = 0;
    fetches     = 0;
    model_reset();

    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 8'd0);

    mode = 0; stray_en = 0;
    run_line(8'd0, 1);
    mode = 1; stray_en = 1;
    run_line(8'd65, 1);
    mode = 2; stray_en = 1;
    run_line(8'd191, 1);
    mode = 1; stray_en = 0;
    run_line(8'($urandom_range(0, SCREEN_LINES - 1)), 0);
    mode = 1; stray_en = 1; rst_pending = 1;
    run_line(8'($urandom_range(0, SCREEN_LINES - 1)), 1);
    mode = 1; stray_en = 1;
    run_line(8'($urandom_range(0, SCREEN_LINES - 1)), 1);

    mode = 0; stray_en = 0;
    for (int i = 0; i < 120; i++) applyStimulus(0, 0, 0, 0, (i == 100), 8'd0);
    checkOutput("reads_drained", rq.size(), 0);
    checkOutput("reset_mid_fetch_taken", rst_pending, 0);

    $display("[TB] fetches started: %0d", fetches);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
